sci_master: RTL and testbench

- Bit-serial SCI requester; sits directly upstream of the neuron wrapper's SCI slave port.
- Converts parallel register write/read commands from a host-side controller or test sequencer into the serial SCI_CSN/SCI_REQ frame.
- Collects the slave's SCI_RESP/SCI_ACK reply and returns the result as a single parallel response pulse.
- One transaction in flight at a time.

---
 rtl/sci_pkg.sv | 22 ++
 rtl/sci_shift_reg.sv | 45 ++++
 rtl/sci_master.sv | 195 +++++++++++++++++++
 tb/tb_sci_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sci_pkg.sv
// sci_pkg: shared types and constants for the SCI requester.
//   sci_state_t        - requester FSM states
//   SCI_RNW_READ/WRITE - value of the leading RnW bit of a frame
//   SCI_*_WIDTH_DEF    - default frame field widths
package sci_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        WAIT_ACK,
        RDATA,
        DONE
    } sci_state_t;

    localparam logic SCI_RNW_READ  = 1'b1;
    localparam logic SCI_RNW_WRITE = 1'b0;

    localparam int SCI_ADDR_WIDTH_DEF = 3;
    localparam int SCI_DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/sci_shift_reg.sv
// sci_shift_reg: frame shifter for the SCI requester.
//   Loadable parallel-in/serial-out register for the outgoing frame (MSB first)
//   and an enable-gated serial-in/parallel-out register for read data.
// Ports:
//   clk       in   clock, rising edge
//   load      in   capture load_data into the PISO
//   load_data in   PISO_W  parallel frame
//   shift     in   shift the PISO one place towards the MSB
//   sout      out  current PISO MSB
//   capture   in   shift sin into the SIPO LSB end
//   sin       in   serial input bit
//   sipo_next out  SIPO_W  SIPO contents as they will be after a capture this cycle
// Data registers carry no reset; the owning FSM qualifies their use.
module sci_shift_reg #(
    parameter int PISO_W = 12,
    parameter int SIPO_W = 8
) (
    input  logic              clk,
    input  logic              load,
    input  logic [PISO_W-1:0] load_data,
    input  logic              shift,
    output logic              sout,
    input  logic              capture,
    input  logic              sin,
    output logic [SIPO_W-1:0] sipo_next
);

    logic [PISO_W-1:0] piso_q;
    logic [SIPO_W-1:0] sipo_q;

    always_ff @(posedge clk) begin
        if (load) begin
            piso_q <= load_data;
        end else if (shift) begin
            piso_q <= {piso_q[PISO_W-2:0], 1'b0};
        end
        if (capture) begin
            sipo_q <= sipo_next;
        end
    end

    assign sout      = piso_q[PISO_W-1];
    assign sipo_next = {sipo_q[SIPO_W-2:0], sin};

endmodule

// File: rtl/sci_master.sv
// sci_master: bit-serial SCI requester.
//   Turns one parallel register write/read command into a serial
//   SCI_CSN/SCI_REQ frame (RnW, address, [write data], MSB first), collects
//   the slave's SCI_RESP/SCI_ACK reply and returns one RSP_VALID pulse.
// Ports:
//   CLK, RST                 clock; synchronous active-high reset
//   REQ_VALID/REQ_READY      command handshake (READY only in IDLE)
//   REQ_WRITE, REQ_ADDR, REQ_WDATA   command fields
//   RSP_VALID                one-cycle completion pulse
//   RSP_RDATA                read data (0 for writes), held until next RSP_VALID
//   RSP_ERROR                timeout flag (tied 0 without the timeout feature)
//   BUSY                     high whenever not IDLE
//   SCI_CSN, SCI_REQ         serial select (active-low) and request bit
//   SCI_RESP, SCI_ACK        serial read bit and slave qualifier/acknowledge
// Build option: define SCI_MASTER_TIMEOUT_EN to abort a stalled WAIT_ACK or
//   RDATA after TIMEOUT_CYCLES cycles without ACK, reporting RSP_ERROR=1.
module sci_master
    import sci_pkg::*;
#(
    parameter int ADDR_WIDTH     = SCI_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = SCI_DATA_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERROR,
    output logic                  BUSY,
    output logic                  SCI_CSN,
    output logic                  SCI_REQ,
    input  logic                  SCI_RESP,
    input  logic                  SCI_ACK
);

    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("sci_master: TIMEOUT_CYCLES must be at least 1");
    end

    sci_state_t             state;
    sci_state_t             next_state;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   is_read;
    logic                   accept;
    logic                   shift_en;
    logic                   capture_en;
    logic                   frame_bit;
    logic                   timeout_hit;
    logic                   entering_done;
    logic [DATA_WIDTH-1:0]  rdata_next;
    logic [FRAME_W-1:0]     frame;

    assign accept     = REQ_VALID && (state == IDLE);
    assign shift_en   = (state == HDR) || (state == WDATA);
    assign capture_en = (state == RDATA) && SCI_ACK;
    assign frame      = {(REQ_WRITE ? SCI_RNW_WRITE : SCI_RNW_READ), REQ_ADDR, REQ_WDATA};

    sci_shift_reg #(
        .PISO_W (FRAME_W),
        .SIPO_W (DATA_WIDTH)
    ) u_shift (
        .clk       (CLK),
        .load      (accept),
        .load_data (frame),
        .shift     (shift_en),
        .sout      (frame_bit),
        .capture   (capture_en),
        .sin       (SCI_RESP),
        .sipo_next (rdata_next)
    );

`ifdef SCI_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            rsp_error_q;

    // Abort on the cycle whose increment would make the idle count reach
    // TIMEOUT_CYCLES, so DONE lands TIMEOUT_CYCLES cycles after entry.
    assign timeout_hit = ((state == WAIT_ACK) || (state == RDATA)) &&
                         !SCI_ACK && (to_cnt == TO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt <= '0;
        end else if (next_state != state) begin
            to_cnt <= '0;
        end else if ((state == WAIT_ACK) || (state == RDATA)) begin
            to_cnt <= SCI_ACK ? '0 : to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_error_q <= 1'b0;
        end else if (entering_done) begin
            rsp_error_q <= timeout_hit;
        end
    end

    assign RSP_ERROR = rsp_error_q;
`else
    assign timeout_hit = 1'b0;
    assign RSP_ERROR   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = HDR;
            end
            HDR: begin
                if (bit_cnt == HDR_LAST) next_state = is_read ? RDATA : WDATA;
            end
            WDATA: begin
                if (bit_cnt == DATA_LAST) next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (SCI_ACK || timeout_hit) next_state = DONE;
            end
            RDATA: begin
                if ((SCI_ACK && (bit_cnt == DATA_LAST)) || timeout_hit) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // bit_cnt restarts on every state change; in RDATA only ACK-qualified
    // cycles advance it, so gaps in ACK stretch the read phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (next_state != state) begin
            bit_cnt <= '0;
        end else if (shift_en || capture_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            is_read <= !REQ_WRITE;
        end
    end

    // The response is registered on the edge into DONE so that it appears
    // together with RSP_VALID; the last read bit arrives on that same edge,
    // hence rdata_next rather than the stored SIPO value.
    assign entering_done = (next_state == DONE) && (state != DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            RSP_RDATA <= '0;
        end else if (entering_done) begin
            if (timeout_hit || (state != RDATA)) begin
                RSP_RDATA <= '0;
            end else begin
                RSP_RDATA <= rdata_next;
            end
        end
    end

    assign REQ_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign RSP_VALID = (state == DONE);
    assign SCI_CSN   = !((state == HDR) || (state == WDATA) ||
                         (state == WAIT_ACK) || (state == RDATA));
    assign SCI_REQ   = shift_en ? frame_bit : 1'b0;

endmodule

// File: tb/tb_sci_master.sv
// tb_sci_master: directed self-checking bench for sci_master.
// Outputs are sampled on the falling edge; inputs are driven there too, so
// a value set at the falling edge of cycle k is sampled at the end of cycle k.
// Cycle 0 is the cycle whose closing rising edge accepts a command.
module tb_sci_master;

    localparam int AW = 3;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic [DW-1:0] REQ_WDATA;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERROR;
    logic          BUSY;
    logic          SCI_CSN;
    logic          SCI_REQ;
    logic          SCI_RESP;
    logic          SCI_ACK;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    sci_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERROR (RSP_ERROR),
        .BUSY      (BUSY),
        .SCI_CSN   (SCI_CSN),
        .SCI_REQ   (SCI_REQ),
        .SCI_RESP  (SCI_RESP),
        .SCI_ACK   (SCI_ACK)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a command during cycle 0; the next rising edge accepts it.
    task automatic start_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = a;
        REQ_WDATA = d;
        check("ready_idle", 32'(REQ_READY), 32'd1);
    endtask

    // Check frame bits first..last (bit 1 = RnW) in cycles first..last.
    task automatic check_frame(input logic [11:0] bits, input int first, input int last,
                               input logic drop_valid, input logic ack_in_hdr);
        for (int i = first; i <= last; i++) begin
            @(negedge CLK);
            if (drop_valid) REQ_VALID = 1'b0;
            SCI_ACK = ack_in_hdr && (i <= 1 + AW);
            check($sformatf("req_bit%0d", i), 32'(SCI_REQ), 32'(bits[12-i]));
            check("csn_frame", 32'(SCI_CSN), 32'd0);
            check("ready_frame", 32'(REQ_READY), 32'd0);
        end
        SCI_ACK = 1'b0;
    endtask

    // Slave returns val MSB first; an idle ACK-low cycle (with a wrong RESP
    // value) is inserted before bit indices gap_a and gap_b.
    task automatic slave_read(input logic [DW-1:0] val, input int gap_a, input int gap_b);
        for (int b = DW - 1; b >= 0; b--) begin
            if (b == gap_a || b == gap_b) begin
                @(negedge CLK);
                SCI_ACK  = 1'b0;
                SCI_RESP = ~val[b];
                check("rsp_early_gap", 32'(RSP_VALID), 32'd0);
                check("req_low_rdata", 32'(SCI_REQ), 32'd0);
            end
            @(negedge CLK);
            SCI_ACK  = 1'b1;
            SCI_RESP = val[b];
            check("rsp_early", 32'(RSP_VALID), 32'd0);
            check("csn_rdata", 32'(SCI_CSN), 32'd0);
        end
        @(negedge CLK);
        SCI_ACK  = 1'b0;
        SCI_RESP = 1'b0;
        check("rd_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("rd_rdata", 32'(RSP_RDATA), 32'(val));
        check("rd_error", 32'(RSP_ERROR), 32'd0);
        check("rd_csn_done", 32'(SCI_CSN), 32'd1);
    endtask

    initial begin
        logic seen;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        SCI_RESP  = 1'b0;
        SCI_ACK   = 1'b0;

        // Reset state after one edge with RST high
        @(negedge CLK);
        check("rst_csn", 32'(SCI_CSN), 32'd1);
        check("rst_req", 32'(SCI_REQ), 32'd0);
        check("rst_ready", 32'(REQ_READY), 32'd1);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rdata", 32'(RSP_RDATA), 32'd0);
        check("rst_error", 32'(RSP_ERROR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;

        // Write addr 3 data 0xA5; ACK held high through HDR must be ignored
        start_cmd(1'b1, 3'd3, 8'hA5);
        check_frame(12'h3A5, 1, 12, 1'b1, 1'b1);
        for (int c = 13; c <= 15; c++) begin
            @(negedge CLK);
            check("wait_csn", 32'(SCI_CSN), 32'd0);
            check("wait_req", 32'(SCI_REQ), 32'd0);
            check("wait_no_rsp", 32'(RSP_VALID), 32'd0);
            if (c == 15) SCI_ACK = 1'b1;
        end
        @(negedge CLK);
        SCI_ACK = 1'b0;
        check("wr_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("wr_rdata", 32'(RSP_RDATA), 32'd0);
        check("wr_error", 32'(RSP_ERROR), 32'd0);
        check("wr_csn_done", 32'(SCI_CSN), 32'd1);
        check("wr_ready_done", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        check("wr_ready_after", 32'(REQ_READY), 32'd1);
        check("wr_rsp_single", 32'(RSP_VALID), 32'd0);
        check("wr_busy_after", 32'(BUSY), 32'd0);

        // Read addr 5, slave returns 0x3C with two idle ACK gaps
        start_cmd(1'b0, 3'd5, 8'h00);
        check_frame({1'b1, 3'd5, 8'h00}, 1, 4, 1'b1, 1'b0);
        slave_read(8'h3C, 5, 2);
        @(negedge CLK);
        check("rd_rsp_single", 32'(RSP_VALID), 32'd0);
        check("rd_rdata_hold", 32'(RSP_RDATA), 32'h3C);
        check("rd_ready_after", 32'(REQ_READY), 32'd1);

        // Back-to-back: REQ_VALID held high, write then read
        start_cmd(1'b1, 3'd1, 8'h0F);
        check_frame(12'h10F, 1, 1, 1'b0, 1'b0);
        REQ_WRITE = 1'b0;
        REQ_ADDR  = 3'd2;
        check_frame(12'h10F, 2, 12, 1'b0, 1'b0);
        @(negedge CLK);
        check("b2b_wait_csn", 32'(SCI_CSN), 32'd0);
        SCI_ACK = 1'b1;
        @(negedge CLK);
        SCI_ACK = 1'b0;
        check("b2b_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("b2b_wr_rdata", 32'(RSP_RDATA), 32'd0);
        check("b2b_csn_done", 32'(SCI_CSN), 32'd1);
        check("b2b_no_accept_done", 32'(REQ_READY), 32'd0);
        @(negedge CLK);
        check("b2b_ready_idle", 32'(REQ_READY), 32'd1);
        check("b2b_csn_idle", 32'(SCI_CSN), 32'd1);
        check("b2b_rsp_single", 32'(RSP_VALID), 32'd0);
        check_frame({1'b1, 3'd2, 8'h00}, 1, 4, 1'b1, 1'b0);
        slave_read(8'h81, -1, -1);

        // Read with no ACK at all
        start_cmd(1'b0, 3'd0, 8'h00);
        check_frame({1'b1, 3'd0, 8'h00}, 1, 4, 1'b1, 1'b0);
`ifdef SCI_MASTER_TIMEOUT_EN
        for (int c = 5; c <= 14; c++) begin
            @(negedge CLK);
            check("to_busy", 32'(BUSY), 32'd1);
            check("to_no_rsp", 32'(RSP_VALID), 32'd0);
        end
        @(negedge CLK);
        check("to_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("to_error", 32'(RSP_ERROR), 32'd1);
        check("to_rdata", 32'(RSP_RDATA), 32'd0);
        check("to_csn", 32'(SCI_CSN), 32'd1);
        @(negedge CLK);
        check("to_idle", 32'(BUSY), 32'd0);
`else
        for (int c = 5; c <= 24; c++) begin
            @(negedge CLK);
            check("stall_busy", 32'(BUSY), 32'd1);
            check("stall_no_rsp", 32'(RSP_VALID), 32'd0);
            check("stall_csn", 32'(SCI_CSN), 32'd0);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("stall_rst_busy", 32'(BUSY), 32'd0);
        check("stall_rst_rdata", 32'(RSP_RDATA), 32'd0);
`endif

        // Reset pulsed during WDATA bit 4 (cycle 9)
        start_cmd(1'b1, 3'd6, 8'hFF);
        check_frame(12'h6FF, 1, 9, 1'b1, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_csn", 32'(SCI_CSN), 32'd1);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_ready", 32'(REQ_READY), 32'd1);
        check("mid_rst_req", 32'(SCI_REQ), 32'd0);
        check("mid_rst_rsp", 32'(RSP_VALID), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            SCI_ACK = c[0];
            @(negedge CLK);
            if (RSP_VALID || BUSY) seen = 1'b1;
        end
        SCI_ACK = 1'b0;
        check("mid_rst_no_late_rsp", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
